ysyx_22041211_ifu: RTL and testbench

//  Instruction fetch unit for the NPC core; the stage directly upstream of the decoder.

---
 rtl/ysyx_22041211_ifu_pkg.sv | 16 +
 rtl/ysyx_22041211_ifu.sv | 132 +++++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings, AXI response codes, reset PC.
package ysyx_22041211_ifu_pkg;

    localparam logic [1:0] IFU_IDLE = 2'd0;
    localparam logic [1:0] IFU_REQ  = 2'd1;
    localparam logic [1:0] IFU_RESP = 2'd2;
    localparam logic [1:0] IFU_OUT  = 2'd3;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [31:0] IFU_RESET_PC  = 32'h8000_0000;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per AXI4-Lite read and hands
// {pc, inst, fault} to the decoder over a valid/ready handshake; accepts execute-stage redirects.
module ysyx_22041211_ifu
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int unsigned           ADDR_LEN = 32,
    parameter int unsigned           DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0]   RESET_PC = ADDR_LEN'(IFU_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    output logic [ADDR_LEN-1:0] araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [DATA_LEN-1:0] inst_o,
    output logic                fault_o,
    output logic                valid_o,
    input  logic                ready_i
);

    logic [1:0]          state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic                stale_q, stale_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_LEN-1:0] araddr_q, araddr_d;
    logic [ADDR_LEN-1:0] pc_out_q, pc_out_d;
    logic [DATA_LEN-1:0] inst_q, inst_d;
    logic                fault_q, fault_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stale_d   = stale_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        pc_out_d  = pc_out_q;
        inst_d    = inst_q;
        fault_d   = fault_q;

        case (state_q)
            IFU_IDLE: state_d = IFU_REQ;
            IFU_REQ: begin
                if (arvalid_q) begin
                    // An issued AR keeps its address; a redirect only marks its beat for discard.
                    if (arready_i) begin
                        arvalid_d = 1'b0;
                        state_d   = IFU_RESP;
                    end
                    if (redirect_valid_i) begin
                        stale_d = 1'b1;
                    end
                end else if (!redirect_valid_i) begin
                    if (pc_misaligned(pc_q[1:0])) begin
                        pc_out_d = pc_q;
                        inst_d   = '0;
                        fault_d  = 1'b1;
                        state_d  = IFU_OUT;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = pc_q;
                    end
                end
            end
            IFU_RESP: begin
                if (rvalid_i) begin
                    if (stale_q || redirect_valid_i) begin
                        stale_d = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        pc_out_d = pc_q;
                        inst_d   = rdata_i;
                        fault_d  = (rresp_i != AXI_RESP_OKAY);
                        state_d  = IFU_OUT;
                    end
                end else if (redirect_valid_i) begin
                    stale_d = 1'b1;
                end
            end
            IFU_OUT: begin
                if (redirect_valid_i || ready_i) begin
                    state_d = IFU_REQ;
                end
                if (ready_i) begin
                    pc_d = pc_q + ADDR_LEN'(4);
                end
            end
            default: state_d = IFU_IDLE;
        endcase

        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IFU_IDLE;
            pc_q      <= RESET_PC;
            stale_q   <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= RESET_PC;
            pc_out_q  <= RESET_PC;
            inst_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stale_q   <= stale_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            pc_out_q  <= pc_out_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
        end
    end

    assign araddr_o  = araddr_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = (state_q == IFU_RESP);
    assign valid_o   = (state_q == IFU_OUT);
    assign pc_o      = pc_out_q;
    assign inst_o    = inst_q;
    assign fault_o   = fault_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for the fetch unit: AXI-Lite memory responder, program-order PC model and directed tests.
module tb_ysyx_22041211_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        rvalid_i = 1'b0;
    logic        rready_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fault_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    ysyx_22041211_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .araddr_o         (araddr_o),
        .arvalid_o        (arvalid_o),
        .arready_i        (arready_i),
        .rdata_i          (rdata_i),
        .rresp_i          (rresp_i),
        .rvalid_i         (rvalid_i),
        .rready_o         (rready_o),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .fault_o          (fault_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr == RESET_PC) ? 32'h0000_0013 : (addr ^ 32'hA5A5_0000);
    endfunction

    // Memory responder knobs and state
    int          ar_delay = 0;
    int          r_delay  = 0;
    logic        poison   = 1'b0;
    int          ar_cnt   = 0;
    int          r_cnt    = 0;
    logic        pending  = 1'b0;
    logic [31:0] pend_addr = '0;
    int          ar_count = 0;
    int          r_beats  = 0;
    logic [31:0] last_ar_addr = '0;

    // Architectural model: the PC of the next instruction the decoder must see
    logic [31:0] model_pc = RESET_PC;
    logic        e_arvalid = 1'b0, e_arready = 1'b0, e_valid = 1'b0, e_ready = 1'b0;
    logic        e_redir = 1'b0;
    logic [31:0] e_araddr = '0;

    always @(posedge clk) begin
        e_arvalid <= arvalid_o;
        e_arready <= arready_i;
        e_araddr  <= araddr_o;
        e_valid   <= valid_o;
        e_ready   <= ready_i;
        e_redir   <= redirect_valid_i;
        if (!rst) begin
            model_pc <= RESET_PC;
            pending  <= 1'b0;
        end else begin
            if (arvalid_o && arready_i) begin
                pending      <= 1'b1;
                pend_addr    <= araddr_o;
                ar_count     <= ar_count + 1;
                last_ar_addr <= araddr_o;
            end
            if (rvalid_i && rready_o) begin
                pending <= 1'b0;
                r_beats <= r_beats + 1;
            end
            if (redirect_valid_i) model_pc <= redirect_pc_i;
            else if (valid_o && ready_i) model_pc <= model_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            arready_i = 1'b0;
            rvalid_i  = 1'b0;
            ar_cnt    = 0;
            r_cnt     = 0;
        end else begin
            if (arvalid_o && !pending) begin
                if (ar_cnt >= ar_delay) begin
                    arready_i = 1'b1;
                    ar_cnt    = 0;
                end else begin
                    arready_i = 1'b0;
                    ar_cnt++;
                end
            end else begin
                arready_i = 1'b0;
            end
            if (pending) begin
                if (r_cnt >= r_delay) rvalid_i = 1'b1;
                else begin
                    rvalid_i = 1'b0;
                    r_cnt++;
                end
            end else begin
                rvalid_i = 1'b0;
                r_cnt    = 0;
            end
            rdata_i = poison ? 32'hDEAD_BEEF : mem_word(pend_addr);
            rresp_i = (pend_addr == ERR_ADDR) ? 2'b10 : 2'b00;
        end
    end

    // Per-cycle comparison against the model and AXI/handshake stability rules
    always @(negedge clk) begin
        if (rst) begin
            if (valid_o) begin
                check32("pc_o", pc_o, model_pc);
                check32("inst_o", inst_o, (model_pc[1:0] != 2'b00) ? 32'h0 : mem_word(model_pc));
                check32("fault_o", {31'b0, fault_o},
                        {31'b0, (model_pc[1:0] != 2'b00) || (model_pc == ERR_ADDR)});
            end
            if (e_arvalid && !e_arready) begin
                check32("arvalid_hold", {31'b0, arvalid_o}, 32'h1);
                check32("araddr_hold", araddr_o, e_araddr);
            end
            if (e_valid && !e_ready && !e_redir) begin
                check32("valid_hold", {31'b0, valid_o}, 32'h1);
            end
            if (arvalid_o) begin
                check32("araddr_align", {30'b0, araddr_o[1:0]}, 32'h0);
                check32("rready_in_req", {31'b0, rready_o}, 32'h0);
            end
        end
    end

    task automatic wait_valid(input string name);
        for (int i = 0; i < 64; i++) begin
            if (valid_o) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s: valid_o timeout, got 0, expected 1", name);
    endtask

    task automatic wait_ar(input string name, input int n);
        for (int i = 0; i < 64; i++) begin
            if (ar_count >= n) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s: AR timeout, got %0d, expected %0d", name, ar_count, n);
    endtask

    task automatic accept();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target, input logic with_ready);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = target;
        ready_i          = with_ready;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        ready_i          = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check32("rst_arvalid", {31'b0, arvalid_o}, 32'h0);
        check32("rst_rready", {31'b0, rready_o}, 32'h0);
        check32("rst_valid", {31'b0, valid_o}, 32'h0);
        check32("rst_pc", pc_o, 32'h8000_0000);
        check32("rst_inst", inst_o, 32'h0);
        check32("rst_fault", {31'b0, fault_o}, 32'h0);
        rst = 1'b1;

        // Zero-wait first fetch
        wait_ar("t1_ar", 1);
        check32("t1_ar0", last_ar_addr, 32'h8000_0000);
        wait_valid("t1_valid");
        check32("t1_pc", pc_o, 32'h8000_0000);
        check32("t1_inst", inst_o, 32'h0000_0013);
        ar_delay = 3;
        accept();

        // Slow AR channel
        wait_ar("t2_ar", 2);
        check32("t1_ar1", last_ar_addr, 32'h8000_0004);
        ar_delay = 0;

        // Decoder stall
        wait_valid("t3_valid");
        check32("t3_pc", pc_o, 32'h8000_0004);
        n = ar_count;
        repeat (5) @(negedge clk);
        check32("t3_valid_held", {31'b0, valid_o}, 32'h1);
        check32("t3_no_ar", ar_count, n);
        r_delay = 3;
        accept();

        // Redirect while the response is outstanding
        for (int i = 0; i < 64 && !rready_o; i++) @(negedge clk);
        check32("t4_in_resp", {31'b0, rready_o}, 32'h1);
        poison = 1'b1;
        n = r_beats;
        redirect(32'h8000_0100, 1'b0);
        for (int i = 0; i < 64 && r_beats == n; i++) @(negedge clk);
        poison  = 1'b0;
        r_delay = 0;
        n = ar_count;
        wait_ar("t4_ar", n + 1);
        check32("t4_ar_addr", last_ar_addr, 32'h8000_0100);
        wait_valid("t4_valid");
        check32("t4_pc", pc_o, 32'h8000_0100);
        check32("t4_inst", inst_o, 32'h25A5_0100);

        // Misaligned target from OUT
        n = ar_count;
        redirect(32'h8000_0102, 1'b0);
        check32("t5_valid_drop", {31'b0, valid_o}, 32'h0);
        wait_valid("t5_valid");
        check32("t5_pc", pc_o, 32'h8000_0102);
        check32("t5_fault", {31'b0, fault_o}, 32'h1);
        check32("t5_inst", inst_o, 32'h0);
        check32("t5_no_ar", ar_count, n);

        // Redirect together with ready, onto an address that returns an error response
        redirect(32'h8000_0008, 1'b1);
        wait_valid("t6_valid");
        check32("t6_pc", pc_o, 32'h8000_0008);
        check32("t6_fault", {31'b0, fault_o}, 32'h1);
        check32("t6_inst", inst_o, 32'h25A5_0008);
        n = ar_count;
        accept();
        wait_ar("t6_ar", n + 1);
        check32("t6_ar_next", last_ar_addr, 32'h8000_000C);
        wait_valid("t6_valid2");
        check32("t6_pc2", pc_o, 32'h8000_000C);
        check32("t6_fault2", {31'b0, fault_o}, 32'h0);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFFC, 1'b0);
        wait_valid("wrap_valid");
        check32("wrap_pc", pc_o, 32'hFFFF_FFFC);
        n = ar_count;
        accept();
        wait_ar("wrap_ar", n + 1);
        check32("wrap_ar_addr", last_ar_addr, 32'h0);
        wait_valid("wrap_valid2");
        check32("wrap_pc2", pc_o, 32'h0);
        accept();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
